// File: rtl/svc_rv_regfile.sv
// svc_rv_regfile: RISC-V integer register file with two registered read ports and one WB write port.
// Define SVC_RV_REGFILE_SB_EN to build the scoreboard that tracks long-latency destinations.
module svc_rv_regfile #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            rd_en,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            reg_write_wb,
    input  logic [AW-1:0]   rd_wb,
    input  logic [XLEN-1:0] rd_data_wb,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic            sb_flush,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    logic [XLEN-1:0] regs [NREGS];
    logic [AW-1:0]   rs1_q;
    logic [AW-1:0]   rs2_q;
    logic [XLEN-1:0] rs1_next;
    logic [XLEN-1:0] rs2_next;
    logic            wr_en;

    assign wr_en = reg_write_wb && (rd_wb != '0);

    // wr_en already excludes x0, so a hold-path hit implies a nonzero latched address
    always_comb begin
        rs1_next = rs1_data;
        if (rd_en) begin
            if (rs1_addr == '0) begin
                rs1_next = '0;
            end else if (wr_en && rd_wb == rs1_addr) begin
                rs1_next = rd_data_wb;
            end else begin
                rs1_next = regs[rs1_addr];
            end
        end else if (wr_en && rd_wb == rs1_q) begin
            rs1_next = rd_data_wb;
        end
    end

    always_comb begin
        rs2_next = rs2_data;
        if (rd_en) begin
            if (rs2_addr == '0) begin
                rs2_next = '0;
            end else if (wr_en && rd_wb == rs2_addr) begin
                rs2_next = rd_data_wb;
            end else begin
                rs2_next = regs[rs2_addr];
            end
        end else if (wr_en && rd_wb == rs2_q) begin
            rs2_next = rd_data_wb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            rs1_data <= '0;
            rs2_data <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
        end else begin
            if (wr_en) begin
                regs[rd_wb] <= rd_data_wb;
            end
            rs1_data <= rs1_next;
            rs2_data <= rs2_next;
            if (rd_en) begin
                rs1_q <= rs1_addr;
                rs2_q <= rs2_addr;
            end
        end
    end

`ifdef SVC_RV_REGFILE_SB_EN
    logic [NREGS-1:0] busy;

    // Later assignments win: a new issue beats a WB clear, and x0 is forced idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (sb_flush) begin
            busy <= '0;
        end else begin
            if (reg_write_wb) begin
                busy[rd_wb] <= 1'b0;
            end
            if (issue_en) begin
                busy[issue_rd] <= 1'b1;
            end
            busy[0] <= 1'b0;
        end
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];
`else
    logic sb_unused;

    assign sb_unused = ^{issue_en, issue_rd, sb_flush};
    assign rs1_busy  = 1'b0;
    assign rs2_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_svc_rv_regfile.sv
// tb_svc_rv_regfile: directed scoreboard bench for svc_rv_regfile.
// Stimulus queues expectations; a monitor pops and compares after each edge or reset.
module tb_svc_rv_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        reg_write_wb = 1'b0;
    logic [4:0]  rd_wb = '0;
    logic [31:0] rd_data_wb = '0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        sb_flush = 1'b0;
    logic        rs1_busy;
    logic        rs2_busy;

    svc_rv_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rd_en        (rd_en),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .reg_write_wb (reg_write_wb),
        .rd_wb        (rd_wb),
        .rd_data_wb   (rd_data_wb),
        .issue_en     (issue_en),
        .issue_rd     (issue_rd),
        .sb_flush     (sb_flush),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          tgt;
        string       name;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
        logic [3:0]  m;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    // mask bits: [0] rs1_data, [1] rs2_data, [2] rs1_busy, [3] rs2_busy
    function automatic void expect_v(string nm, logic [31:0] d1, logic [31:0] d2,
                                     logic b1, logic b2, logic [3:0] m);
        exp_t e;
        e.tgt = cyc + 1;
        e.name = nm;
        e.d1 = d1;
        e.d2 = d2;
        e.b1 = b1;
        e.b2 = b2;
        e.m = m;
        q.push_back(e);
    endfunction

    function automatic void expect_now(string nm);
        exp_t e;
        e.tgt = -1;
        e.name = nm;
        e.d1 = '0;
        e.d2 = '0;
        e.b1 = 1'b0;
        e.b2 = 1'b0;
        e.m = 4'b1111;
        q.push_back(e);
    endfunction

    function automatic logic sb(logic b);
`ifdef SVC_RV_REGFILE_SB_EN
        return b;
`else
        return 1'b0 & b;
`endif
    endfunction

    initial begin
        exp_t e;
        bit bad;
        forever begin
            @(posedge clk or posedge rst);
            #2;
            while (q.size() > 0 &&
                   (q[0].tgt == cyc || (q[0].tgt < 0 && rst === 1'b1) ||
                    (q[0].tgt >= 0 && q[0].tgt < cyc))) begin
                e = q.pop_front();
                vectors++;
                if (e.tgt >= 0 && e.tgt < cyc) begin
                    miscompares++;
                    $display("FAIL %s: not checked at cycle %0d, now %0d", e.name, e.tgt, cyc);
                end else begin
                    bad = 0;
                    if (e.m[0] && rs1_data !== e.d1) bad = 1;
                    if (e.m[1] && rs2_data !== e.d2) bad = 1;
                    if (e.m[2] && rs1_busy !== e.b1) bad = 1;
                    if (e.m[3] && rs2_busy !== e.b2) bad = 1;
                    if (bad) begin
                        miscompares++;
                        $display("FAIL %s: got rs1=%h rs2=%h b1=%b b2=%b, required rs1=%h rs2=%h b1=%b b2=%b (mask %b)",
                                 e.name, rs1_data, rs2_data, rs1_busy, rs2_busy,
                                 e.d1, e.d2, e.b1, e.b2, e.m);
                    end
                end
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic set_rw(logic re, logic [4:0] a1, logic [4:0] a2,
                          logic we, logic [4:0] wd, logic [31:0] wdat);
        rd_en = re;
        rs1_addr = a1;
        rs2_addr = a2;
        reg_write_wb = we;
        rd_wb = wd;
        rd_data_wb = wdat;
    endtask

    initial begin
        nxt();
        expect_v("reset", 32'h0, 32'h0, 1'b0, 1'b0, 4'b1111);
        nxt();
        rst = 1'b0;

        set_rw(0, 0, 0, 1, 5, 32'hDEADBEEF);
        nxt();
        set_rw(1, 5, 0, 0, 0, 32'h0);
        expect_v("basic_read", 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 4'b0011);
        nxt();

        set_rw(1, 0, 0, 1, 0, 32'h12345678);
        expect_v("x0_write_bypass", 32'h0, 32'h0, 1'b0, 1'b0, 4'b0011);
        nxt();
        set_rw(1, 0, 0, 0, 0, 32'h0);
        expect_v("x0_read", 32'h0, 32'h0, 1'b0, 1'b0, 4'b0011);
        nxt();

        set_rw(0, 0, 0, 1, 7, 32'h11);
        nxt();
        set_rw(1, 7, 7, 1, 7, 32'h22);
        expect_v("bypass_same", 32'h22, 32'h22, 1'b0, 1'b0, 4'b0011);
        nxt();
        set_rw(1, 7, 7, 0, 0, 32'h0);
        expect_v("bypass_stored", 32'h22, 32'h22, 1'b0, 1'b0, 4'b0011);
        nxt();

        set_rw(0, 0, 0, 1, 9, 32'h1);
        nxt();
        set_rw(1, 9, 5, 0, 0, 32'h0);
        expect_v("stall_read", 32'h1, 32'hDEADBEEF, 1'b0, 1'b0, 4'b0011);
        nxt();
        set_rw(0, 3, 4, 1, 10, 32'hAA);
        expect_v("stall_other_wr", 32'h1, 32'hDEADBEEF, 1'b0, 1'b0, 4'b0011);
        nxt();
        set_rw(0, 3, 4, 1, 9, 32'h2);
        expect_v("stall_refresh1", 32'h2, 32'hDEADBEEF, 1'b0, 1'b0, 4'b0011);
        nxt();
        set_rw(0, 3, 4, 1, 5, 32'h55);
        expect_v("stall_refresh2", 32'h2, 32'h55, 1'b0, 1'b0, 4'b0011);
        nxt();
        set_rw(1, 10, 9, 0, 0, 32'h0);
        expect_v("after_stall", 32'hAA, 32'h2, 1'b0, 1'b0, 4'b0011);
        nxt();

        set_rw(0, 3, 4, 0, 0, 32'h0);
        issue_en = 1'b1;
        issue_rd = 5'd3;
        expect_v("sb_issue", 32'h0, 32'h0, sb(1'b1), 1'b0, 4'b1100);
        nxt();
        set_rw(0, 3, 4, 1, 3, 32'h33);
        expect_v("sb_set_wins", 32'h0, 32'h0, sb(1'b1), 1'b0, 4'b1100);
        nxt();
        issue_en = 1'b0;
        set_rw(0, 3, 4, 1, 3, 32'h34);
        expect_v("sb_wb_clear", 32'h0, 32'h0, 1'b0, 1'b0, 4'b1100);
        nxt();
        set_rw(0, 3, 4, 0, 0, 32'h0);
        issue_en = 1'b1;
        issue_rd = 5'd4;
        expect_v("sb_issue4", 32'h0, 32'h0, 1'b0, sb(1'b1), 4'b1100);
        nxt();
        set_rw(0, 6, 4, 0, 0, 32'h0);
        issue_rd = 5'd6;
        sb_flush = 1'b1;
        expect_v("sb_flush", 32'h0, 32'h0, 1'b0, 1'b0, 4'b1100);
        nxt();
        sb_flush = 1'b0;
        issue_rd = 5'd0;
        set_rw(0, 0, 0, 0, 0, 32'h0);
        expect_v("sb_x0_issue", 32'h0, 32'h0, 1'b0, 1'b0, 4'b1100);
        nxt();
        issue_en = 1'b0;
        expect_v("sb_x0_hold", 32'h0, 32'h0, 1'b0, 1'b0, 4'b1100);
        nxt();
        set_rw(0, 8, 0, 0, 0, 32'h0);
        issue_en = 1'b1;
        issue_rd = 5'd8;
        expect_v("sb_issue8", 32'h0, 32'h0, sb(1'b1), 1'b0, 4'b1100);
        nxt();
        expect_v("sb_reissue8", 32'h0, 32'h0, sb(1'b1), 1'b0, 4'b1100);
        nxt();
        issue_en = 1'b0;

        for (int i = 1; i < 32; i++) begin
            set_rw(0, 0, 0, 1, 5'(i), 32'h1000_0000 | 32'(i));
            nxt();
        end
        set_rw(1, 31, 1, 0, 0, 32'h0);
        expect_v("loaded", 32'h1000_001F, 32'h1000_0001, 1'b0, 1'b0, 4'b0011);
        nxt();
        set_rw(0, 31, 1, 0, 0, 32'h0);
        issue_en = 1'b1;
        issue_rd = 5'd31;
        expect_v("pre_reset", 32'h1000_001F, 32'h1000_0001, sb(1'b1), 1'b0, 4'b1111);
        nxt();
        issue_en = 1'b0;
        set_rw(0, 31, 1, 1, 31, 32'hFFFF_FFFF);
        expect_now("async_reset");
        #2;
        rst = 1'b1;
        nxt();
        set_rw(0, 0, 0, 0, 0, 32'h0);
        rst = 1'b0;
        nxt();

        for (int i = 0; i < 32; i++) begin
            set_rw(1, 5'(i), 5'(31 - i), 0, 0, 32'h0);
            expect_v("post_reset_read", 32'h0, 32'h0, 1'b0, 1'b0, 4'b1111);
            nxt();
        end
        set_rw(0, 0, 0, 0, 0, 32'h0);
        repeat (3) nxt();

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: never checked, due at cycle %0d", e.name, e.tgt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
